// File: rtl/j1_ifetch.sv
// J1 instruction fetch: classic Wishbone read master feeding a small prefetch FIFO
// that presents {pc, instr} to decode over valid/ready; redirects flush and restart.
module j1_ifetch #(
    parameter int unsigned   AW       = 13,
    parameter int unsigned   DEPTH    = 2,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [15:0]   instr,
    output logic [AW-1:0] instr_pc,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [1:0]    wb_sel_o,
    output logic [AW-1:0] wb_adr_o,
    input  logic [15:0]   wb_dat_i,
    input  logic          wb_ack_i
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = 16;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP} state_e;

    state_e          state_q;
    logic            cyc_q;
    logic [AW-1:0]   adr_q;
    logic [AW-1:0]   fetch_pc_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [DW-1:0]   data_mem_q [DEPTH];
    logic [AW-1:0]   pc_mem_q   [DEPTH];

    logic            ack;
    logic            push;
    logic            pop;
    logic            space;
    logic [CW-1:0]   count_d;

    // FIFO occupancy after this edge decides whether another read may start
    always_comb begin
        ack     = cyc_q & wb_ack_i;
        push    = (state_q == S_FETCH) & ack & ~redirect;
        pop     = (count_q != '0) & instr_ready;
        count_d = count_q + CW'(push) - CW'(pop);
        space   = count_d < CW'(DEPTH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cyc_q      <= 1'b0;
            adr_q      <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (redirect) begin
                        state_q    <= S_FETCH;
                        cyc_q      <= 1'b1;
                        adr_q      <= redirect_pc;
                        fetch_pc_q <= redirect_pc;
                    end else if (space) begin
                        state_q <= S_FETCH;
                        cyc_q   <= 1'b1;
                        adr_q   <= fetch_pc_q;
                    end
                end
                S_FETCH: begin
                    if (ack) begin
                        if (redirect) begin
                            adr_q      <= redirect_pc;
                            fetch_pc_q <= redirect_pc;
                        end else begin
                            fetch_pc_q <= adr_q + AW'(1);
                            if (space) begin
                                adr_q <= adr_q + AW'(1);
                            end else begin
                                state_q <= S_IDLE;
                                cyc_q   <= 1'b0;
                            end
                        end
                    end else if (redirect) begin
                        // read already issued; let it finish, then discard its data
                        state_q    <= S_DROP;
                        fetch_pc_q <= redirect_pc;
                    end
                end
                S_DROP: begin
                    if (ack) begin
                        state_q <= S_FETCH;
                        adr_q   <= redirect ? redirect_pc : fetch_pc_q;
                    end
                    if (redirect) begin
                        fetch_pc_q <= redirect_pc;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cyc_q   <= 1'b0;
                end
            endcase
        end
    end

    // Redirect empties the FIFO, overriding any push or pop in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= wb_dat_i;
            pc_mem_q[wr_ptr_q]   <= adr_q;
        end
    end

    assign instr_valid = (count_q != '0);
    assign instr       = data_mem_q[rd_ptr_q];
    assign instr_pc    = pc_mem_q[rd_ptr_q];
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = 1'b0;
    assign wb_sel_o    = 2'b11;
    assign wb_adr_o    = adr_q;
endmodule

// File: tb/tb_j1_ifetch.sv
// Bench for j1_ifetch: directed fetch/redirect/reset scenarios against a Wishbone
// slave model, plus randomized traffic checked against an instruction-stream model.
module tb_j1_ifetch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [12:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [12:0] instr_pc;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [1:0]  wb_sel_o;
    logic [12:0] wb_adr_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;

    int n_checks = 0;
    int n_errors = 0;

    // slave model: data = A000|adr, ack after a configurable number of wait states
    int   ws_cfg = 0;
    int   ws_rand = 0;
    int   wcnt = 0;
    bit   rand_mode = 1'b0;
    logic stray_ack = 1'b0;
    int   cur_ws;

    assign cur_ws   = rand_mode ? ws_rand : ws_cfg;
    assign wb_dat_i = 16'hA000 | 16'(wb_adr_o);
    assign wb_ack_i = stray_ack | (wb_cyc_o & (wcnt >= cur_ws));

    always @(posedge clk) begin
        if (!wb_cyc_o || wb_ack_i) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (wb_cyc_o && wb_ack_i) ws_rand <= int'($urandom_range(0, 3));
    end

    always #5 clk = ~clk;

    j1_ifetch #(.AW(13), .DEPTH(2), .RESET_PC(13'h0)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    task automatic do_reset(input bit rdy, input int ws);
        @(negedge clk);
        reset = 1'b1; redirect = 1'b0; instr_ready = rdy;
        ws_cfg = ws; rand_mode = 1'b0; stray_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [16:0] got;
        logic [16:0] exp;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        got = {wb_cyc_o, wb_stb_o, wb_adr_o, instr_valid, wb_we_o};
        exp = {1'b0, 1'b0, 13'h0, 1'b0, 1'b0};
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL reset_state: got %h expected %h", got, exp);
        end
        n_checks++;
        if (wb_sel_o !== 2'b11) begin
            n_errors++; $display("FAIL reset_sel: got %b expected 11", wb_sel_o);
        end
    endtask

    task automatic test_stream;
        logic [43:0] got;
        logic [43:0] exp;
        do_reset(1'b1, 0);
        @(negedge clk);
        got = {29'h0, wb_cyc_o, wb_adr_o, instr_valid};
        exp = {29'h0, 1'b1, 13'h0, 1'b0};
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL stream_first: got %h expected %h", got, exp);
        end
        for (int k = 2; k < 10; k++) begin
            @(negedge clk);
            got = {wb_cyc_o, wb_adr_o, instr_valid, instr_pc, instr};
            exp = {1'b1, 13'(k - 1), 1'b1, 13'(k - 2), 16'hA000 | 16'(k - 2)};
            n_checks++;
            if (got !== exp) begin
                n_errors++; $display("FAIL stream_k%0d: got %h expected %h", k, got, exp);
            end
        end
    endtask

    task automatic test_backpressure;
        int reads = 0;
        logic [30:0] got;
        logic [30:0] exp;
        do_reset(1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb_cyc_o) reads++;
        end
        n_checks++;
        if (reads !== 2) begin
            n_errors++; $display("FAIL bp_reads: got %0d expected 2", reads);
        end
        got = {wb_cyc_o, instr_valid, instr_pc, instr};
        exp = {1'b0, 1'b1, 13'h0, 16'hA000};
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL bp_hold: got %h expected %h", got, exp);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        got = {2'b0, wb_cyc_o, wb_adr_o, instr_valid, instr_pc};
        exp = {2'b0, 1'b1, 13'h2, 1'b1, 13'h1};
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL bp_resume: got %h expected %h", got, exp);
        end
        @(negedge clk);
        exp = {2'b0, 1'b1, 13'h3, 1'b1, 13'h2};
        got = {2'b0, wb_cyc_o, wb_adr_o, instr_valid, instr_pc};
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL bp_next: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_drop;
        bit found = 1'b0;
        bit seen_valid = 1'b0;
        logic [28:0] got;
        logic [28:0] exp;
        do_reset(1'b1, 3);
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (wb_cyc_o && wb_adr_o == 13'h5) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_errors++; $display("FAIL drop_reach_adr5: got timeout expected adr 5");
            return;
        end
        redirect = 1'b1; redirect_pc = 13'h0100;
        @(negedge clk);
        redirect = 1'b0;
        got = {14'h0, wb_cyc_o, wb_adr_o, instr_valid};
        exp = {14'h0, 1'b1, 13'h5, 1'b0};
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL drop_hold: got %h expected %h", got, exp);
        end
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) seen_valid = 1'b1;
            if (wb_adr_o != 13'h5) break;
            @(negedge clk);
        end
        n_checks++;
        if (seen_valid !== 1'b0) begin
            n_errors++; $display("FAIL drop_leak: got valid 1 expected 0");
        end
        got = {14'h0, wb_cyc_o, wb_adr_o, instr_valid};
        exp = {14'h0, 1'b1, 13'h0100, 1'b0};
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL drop_restart: got %h expected %h", got, exp);
        end
        for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
        got = {instr_valid, 15'h0, instr_pc} ^ {1'b0, 15'h0, 13'h0};
        exp = {1'b1, 15'h0, 13'h0100};
        n_checks++;
        if (got !== exp || instr !== 16'hA100) begin
            n_errors++; $display("FAIL drop_first: got %h/%h expected %h/a100", got, instr, exp);
        end
    endtask

    task automatic test_redirect_ack;
        bit found = 1'b0;
        logic [29:0] got;
        logic [29:0] exp;
        do_reset(1'b1, 0);
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (wb_cyc_o && wb_adr_o == 13'h7) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_errors++; $display("FAIL rack_reach_adr7: got timeout expected adr 7");
            return;
        end
        redirect = 1'b1; redirect_pc = 13'h0040;
        @(negedge clk);
        redirect = 1'b0;
        got = {15'h0, wb_cyc_o, wb_adr_o, instr_valid};
        exp = {15'h0, 1'b1, 13'h0040, 1'b0};
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL rack_restart: got %h expected %h", got, exp);
        end
        @(negedge clk);
        got = {instr_valid, instr_pc, instr};
        exp = {1'b1, 13'h0040, 16'hA040};
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL rack_first: got %h expected %h", got, exp);
        end
        @(negedge clk);
        got = {instr_valid, instr_pc, instr};
        exp = {1'b1, 13'h0041, 16'hA041};
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL rack_second: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_wrap;
        logic [42:0] got;
        logic [42:0] exp;
        do_reset(1'b1, 0);
        repeat (4) @(negedge clk);
        redirect = 1'b1; redirect_pc = 13'h1FFF;
        @(negedge clk);
        redirect = 1'b0;
        got = {29'h0, wb_cyc_o, wb_adr_o};
        exp = {29'h0, 1'b1, 13'h1FFF};
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL wrap_adr: got %h expected %h", got, exp);
        end
        @(negedge clk);
        got = {wb_adr_o, instr_valid, instr_pc, instr};
        exp = {13'h0, 1'b1, 13'h1FFF, 16'hBFFF};
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL wrap_top: got %h expected %h", got, exp);
        end
        @(negedge clk);
        exp = {13'h1, 1'b1, 13'h0, 16'hA000};
        got = {wb_adr_o, instr_valid, instr_pc, instr};
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL wrap_zero: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_reset_midcycle;
        logic [28:0] got;
        logic [28:0] exp;
        do_reset(1'b0, 3);
        for (int i = 0; i < 50 && !instr_valid; i++) @(negedge clk);
        got = {15'h0, wb_cyc_o, wb_adr_o};
        exp = {15'h0, 1'b1, 13'h1};
        n_checks++;
        if (got !== exp || instr_valid !== 1'b1) begin
            n_errors++; $display("FAIL rstmid_pre: got %h valid %b expected %h valid 1", got, instr_valid, exp);
        end
        reset = 1'b1;
        #1;
        got = {13'h0, wb_cyc_o, wb_stb_o, instr_valid, wb_adr_o};
        exp = {13'h0, 1'b0, 1'b0, 1'b0, 13'h0};
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL rstmid_drop: got %h expected %h", got, exp);
        end
        stray_ack = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        stray_ack = 1'b0;
        got = {14'h0, wb_cyc_o, wb_adr_o, instr_valid};
        exp = {14'h0, 1'b1, 13'h0, 1'b0};
        n_checks++;
        if (got !== exp) begin
            n_errors++; $display("FAIL rstmid_restart: got %h expected %h", got, exp);
        end
        for (int i = 0; i < 50 && !instr_valid; i++) @(negedge clk);
        got = {instr_valid, 15'h0, instr_pc};
        exp = {1'b1, 15'h0, 13'h0};
        n_checks++;
        if (got !== exp || instr !== 16'hA000) begin
            n_errors++; $display("FAIL rstmid_first: got %h/%h expected %h/a000", got, instr, exp);
        end
    endtask

    // model: consumed pcs run sequentially from the last redirect target, data = A000|pc
    task automatic test_random;
        logic [12:0] exp_pc = 13'h0;
        logic [12:0] prev_adr = 13'h0;
        bit          prev_hold = 1'b0;
        int          pops = 0;
        bit          rdy;
        bit          rd;
        logic [12:0] rpc;
        do_reset(1'b1, 0);
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            n_checks++;
            if ({wb_stb_o, wb_we_o, wb_sel_o} !== {wb_cyc_o, 1'b0, 2'b11}) begin
                n_errors++; $display("FAIL rnd_wbctl: got %b expected %b", {wb_stb_o, wb_we_o, wb_sel_o}, {wb_cyc_o, 3'b011});
            end
            if (prev_hold && wb_cyc_o) begin
                n_checks++;
                if (wb_adr_o !== prev_adr) begin
                    n_errors++; $display("FAIL rnd_adr_hold: got %h expected %h", wb_adr_o, prev_adr);
                end
            end
            rdy = ($urandom_range(0, 99) < 70);
            rd  = ($urandom_range(0, 99) < 4);
            rpc = 13'($urandom);
            instr_ready = rdy; redirect = rd; redirect_pc = rpc;
            if (instr_valid && rdy) begin
                n_checks++;
                if ({instr_pc, instr} !== {exp_pc, 3'b101, exp_pc}) begin
                    n_errors++; $display("FAIL rnd_pop: got %h/%h expected %h/%h", instr_pc, instr, exp_pc, {3'b101, exp_pc});
                end
                exp_pc = exp_pc + 13'h1;
                pops++;
            end
            if (rd) exp_pc = rpc;
            prev_hold = wb_cyc_o && !wb_ack_i;
            prev_adr  = wb_adr_o;
            @(negedge clk);
        end
        redirect = 1'b0;
        n_checks++;
        if (pops < 200) begin
            n_errors++; $display("FAIL rnd_throughput: got %0d pops expected >= 200", pops);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_drop();
        test_redirect_ack();
        test_wrap();
        test_reset_midcycle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
